// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit CPU.
// Define SINGLE_STEP_EN to add a step input that gates instruction fetch.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TO_W        = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] instruction,
   input  logic       instr_valid,
   input  logic       mem_ready,
   input  logic       halt_req,
`ifdef SINGLE_STEP_EN
   input  logic       step,
`endif
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       regdst,
   output logic       alusrc,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       memread,
   output logic       memwrite,
   output logic       branch,
   output logic       aluop,
   output logic [2:0] state,
   output logic [7:0] retired,
   output logic       halted,
   output logic       fault
);
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;
   localparam logic [2:0] S_FAULT  = 3'd6;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_JMP = 2'b11;

   logic [2:0]      state_q, state_d;
   logic [1:0]      opcode_q, opcode_d;
   logic [7:0]      retired_q, retired_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            fetch_ok;
   logic            accept;
   logic            to_hit;
   logic            unused_instr;

   assign unused_instr = ^instruction[5:0];

`ifdef SINGLE_STEP_EN
   logic step_pending_q, step_pending_d;

   assign fetch_ok       = step_pending_q | step;
   assign step_pending_d = (step_pending_q | step) & ~accept;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) step_pending_q <= 1'b0;
      else        step_pending_q <= step_pending_d;
   end
`else
   assign fetch_ok = 1'b1;
`endif

   assign accept = (state_q == S_FETCH) & ~halt_req & instr_valid & fetch_ok;
   // Ready is checked before this, so a same-cycle ready beats the timeout.
   assign to_hit = (MEM_TIMEOUT != 0) &&
                   (to_cnt_q + TO_W'(1) == TO_W'(MEM_TIMEOUT));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= S_FETCH;
         opcode_q  <= OP_ADD;
         retired_q <= 8'd0;
         to_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         retired_q <= retired_d;
         to_cnt_q  <= to_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      retired_d = retired_q;
      to_cnt_d  = to_cnt_q;
      unique case (state_q)
         S_FETCH: begin
            if (halt_req) begin
               state_d = S_HALT;
            end else if (accept) begin
               state_d  = S_DECODE;
               opcode_d = instruction[7:6];
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            unique case (opcode_q)
               OP_ADD: state_d = S_WB;
               OP_JMP: begin
                  state_d   = S_FETCH;
                  retired_d = retired_q + 8'd1;
               end
               default: begin
                  state_d  = S_MEM;
                  to_cnt_d = '0;
               end
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (opcode_q == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  state_d   = S_FETCH;
                  retired_d = retired_q + 8'd1;
               end
            end else if (to_hit) begin
               state_d = S_FAULT;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         S_WB: begin
            state_d   = S_FETCH;
            retired_d = retired_q + 8'd1;
         end
         S_HALT:  if (!halt_req) state_d = S_FETCH;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      ir_write = 1'b0;
      pc_write = 1'b0;
      pc_src   = 1'b0;
      regdst   = 1'b0;
      alusrc   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      branch   = 1'b0;
      aluop    = 1'b0;
      halted   = 1'b0;
      fault    = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            ir_write = accept & RESET;
            pc_write = accept & RESET;
         end
         S_EXEC: begin
            unique case (opcode_q)
               OP_ADD: aluop = 1'b1;
               OP_JMP: begin
                  pc_write = 1'b1;
                  pc_src   = 1'b1;
                  branch   = 1'b1;
               end
               default: alusrc = 1'b1;
            endcase
         end
         S_MEM: begin
            alusrc   = 1'b1;
            memread  = (opcode_q == OP_LW);
            memwrite = (opcode_q == OP_SW);
         end
         S_WB: begin
            regwrite = 1'b1;
            regdst   = (opcode_q == OP_ADD);
            memtoreg = (opcode_q == OP_LW);
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
         default: ;
      endcase
   end

   assign state   = state_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random traffic,
// checked every cycle against an instruction-level reference model.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
   localparam int TO = 15;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [7:0] instruction = 8'h00;
   logic       instr_valid = 1'b0;
   logic       mem_ready = 1'b0;
   logic       halt_req = 1'b0;
`ifdef SINGLE_STEP_EN
   logic       step = 1'b1;
`endif
   logic ir_write, pc_write, pc_src, regdst, alusrc, memtoreg;
   logic regwrite, memread, memwrite, branch, aluop, halted, fault;
   logic [2:0] state;
   logic [7:0] retired;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(4)) dut (
      .CLK(CLK), .RESET(RESET), .instruction(instruction),
      .instr_valid(instr_valid), .mem_ready(mem_ready),
      .halt_req(halt_req),
`ifdef SINGLE_STEP_EN
      .step(step),
`endif
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .regdst(regdst), .alusrc(alusrc), .memtoreg(memtoreg),
      .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
      .branch(branch), .aluop(aluop), .state(state),
      .retired(retired), .halted(halted), .fault(fault)
   );

   // Instruction-level model: an instruction in flight is tracked by
   // its age in cycles and whether its memory access has completed.
   bit       m_busy, m_halt, m_fault, m_memdone, rst_seen;
   bit [1:0] m_op;
   int       m_age, m_wait, m_ret;

   function automatic void m_reset();
      m_busy = 0; m_halt = 0; m_fault = 0; m_memdone = 0;
      m_op = 0; m_age = 0; m_wait = 0; m_ret = 0;
   endfunction

   function automatic void m_retire();
      m_busy = 0;
      m_ret  = (m_ret + 1) % 256;
   endfunction

   function automatic logic [2:0] m_state();
      if (m_fault) return 3'd6;
      if (m_halt) return 3'd5;
      if (!m_busy) return 3'd0;
      if (m_age == 1) return 3'd1;
      if (m_age == 2) return 3'd2;
      if (m_op == 2'b00 || m_memdone) return 3'd4;
      return 3'd3;
   endfunction

   logic [23:0] got;
   assign got = {ir_write, pc_write, pc_src, regdst, alusrc, memtoreg,
                 regwrite, memread, memwrite, branch, aluop,
                 halted, fault, state, retired};

   always @(negedge RESET) rst_seen = 1;

   always @(negedge CLK) begin : chk
      logic [2:0]  es;
      logic        acc;
      logic e_ir, e_pcw, e_pcs, e_rd, e_as, e_mtr;
      logic e_rw, e_mr, e_mw, e_br, e_aop;
      logic [23:0] exp;
      if (rst_seen || !RESET) begin
         m_reset();
         rst_seen = 0;
      end
      es  = m_state();
      acc = RESET && es == 3'd0 && !halt_req && instr_valid;
      e_ir = acc; e_pcw = acc; e_pcs = 0; e_rd = 0; e_as = 0; e_mtr = 0;
      e_rw = 0; e_mr = 0; e_mw = 0; e_br = 0; e_aop = 0;
      if (es == 3'd2) begin
         if (m_op == 2'b00) e_aop = 1;
         else if (m_op == 2'b11) begin e_pcw = 1; e_pcs = 1; e_br = 1; end
         else e_as = 1;
      end
      if (es == 3'd3) begin
         e_as = 1; e_mr = (m_op == 2'b01); e_mw = (m_op == 2'b10);
      end
      if (es == 3'd4) begin
         e_rw = 1; e_rd = (m_op == 2'b00); e_mtr = (m_op == 2'b01);
      end
      exp = {e_ir, e_pcw, e_pcs, e_rd, e_as, e_mtr, e_rw, e_mr, e_mw,
             e_br, e_aop, es == 3'd5, es == 3'd6, es, 8'(m_ret)};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, got, exp);
      end
      if (RESET) begin
         if (m_fault) begin
         end else if (m_halt) begin
            if (!halt_req) m_halt = 0;
         end else if (!m_busy) begin
            if (halt_req) m_halt = 1;
            else if (instr_valid) begin
               m_busy = 1; m_op = instruction[7:6]; m_age = 1;
               m_wait = 0; m_memdone = 0;
            end
         end else if (m_age < 3) begin
            if (m_age == 2 && m_op == 2'b11) m_retire();
            else m_age++;
         end else if (m_op == 2'b00 || m_memdone) begin
            m_retire();
         end else if (mem_ready) begin
            if (m_op == 2'b01) m_memdone = 1;
            else m_retire();
         end else begin
            m_wait++;
            if (TO != 0 && m_wait == TO) begin
               m_fault = 1; m_busy = 0;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge CLK); #1;
   endtask

   task automatic smp();
      @(negedge CLK);
   endtask

   task automatic lit(input string nm, input logic [31:0] g,
                      input logic [31:0] e);
      checks++;
      if (g !== e) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, g, e, $time);
      end
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      RESET = 0; instr_valid = 0; mem_ready = 0; halt_req = 0;
      cyc(); cyc();
      RESET = 1;
   endtask

   int add_st[5] = '{0, 1, 2, 4, 0};
   int nrd;
   bit stall;

   initial begin
      do_reset();
      lit("reset_state", state, 0);
      lit("reset_retired", retired, 0);

      instruction = 8'b00011011; instr_valid = 1; mem_ready = 1;
      for (int i = 0; i < 5; i++) begin
         smp();
         lit("add_state", state, add_st[i]);
         lit("add_regwrite", regwrite, i == 3);
         lit("add_regdst", regdst, i == 3);
         if (i == 4) lit("add_retired", retired, 1);
         cyc(); instr_valid = 0;
      end

      do_reset();
      instruction = 8'h40; nrd = 0;
      for (int i = 0; i < 9; i++) begin
         instr_valid = (i == 0); mem_ready = (i >= 6);
         smp();
         if (memread) nrd++;
         if (i == 7) begin
            lit("lw_memtoreg", memtoreg, 1);
            lit("lw_regwrite", regwrite, 1);
         end
         if (i == 8) begin
            lit("lw_state", state, 0);
            lit("lw_retired", retired, 1);
         end
         cyc();
      end
      lit("lw_memread_cycles", nrd, 4);

      do_reset();
      instruction = 8'h80; mem_ready = 0;
      for (int i = 0; i < 20; i++) begin
         instr_valid = (i == 0);
         smp();
         if (i == 17) begin
            lit("sw_mem_state", state, 3);
            lit("sw_memwrite", memwrite, 1);
         end
         if (i == 18) begin
            lit("to_state", state, 6);
            lit("to_fault", fault, 1);
            lit("to_memwrite", memwrite, 0);
         end
         cyc();
      end
      instruction = 8'h00; instr_valid = 1; mem_ready = 1;
      repeat (5) cyc();
      smp();
      lit("fault_sticky", state, 6);
      do_reset();
      smp();
      lit("fault_cleared", fault, 0);

      do_reset();
      instruction = 8'hC5; mem_ready = 1;
      for (int i = 0; i < 4; i++) begin
         instr_valid = (i == 0);
         smp();
         if (i == 2) begin
            lit("jmp_state", state, 2);
            lit("jmp_pc_write", pc_write, 1);
            lit("jmp_pc_src", pc_src, 1);
            lit("jmp_branch", branch, 1);
         end
         if (i == 3) begin
            lit("jmp_back", state, 0);
            lit("jmp_retired", retired, 1);
         end
         cyc();
      end

      do_reset();
      halt_req = 1; instr_valid = 1; instruction = 8'h00;
      smp();
      lit("halt_no_ir", ir_write, 0);
      cyc(); halt_req = 0;
      smp();
      lit("halt_state", state, 5);
      lit("halt_flag", halted, 1);
      cyc();
      smp();
      lit("halt_resume", state, 0);
      lit("halt_accept", ir_write, 1);
      cyc(); instr_valid = 0;
      smp();
      lit("halt_decode", state, 1);
      repeat (4) cyc();

      do_reset();
      instruction = 8'h00; instr_valid = 1; mem_ready = 1;
      for (int i = 0; i <= 1024; i++) begin
         smp();
         if (i == 1020) lit("wrap_255", retired, 255);
         if (i == 1024) lit("wrap_0", retired, 0);
         cyc();
      end
      instr_valid = 0;

      do_reset();
      instruction = 8'h80; mem_ready = 0;
      for (int i = 0; i < 4; i++) begin
         instr_valid = (i == 0);
         smp();
         if (i < 3) cyc();
      end
      lit("mid_mem_memwrite", memwrite, 1);
      #2 RESET = 0;
      #1;
      lit("async_memwrite", memwrite, 0);
      lit("async_state", state, 0);
      @(posedge CLK); #1 RESET = 1;
      smp();
      lit("post_reset_state", state, 0);

      do_reset();
      stall = 0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 59) == 0) stall = ~stall;
         instruction = 8'($urandom);
         instr_valid = ($urandom_range(0, 3) != 0);
         halt_req    = ($urandom_range(0, 19) == 0);
         mem_ready   = stall ? 1'b0 : ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 399) == 0) begin
            RESET = 0;
            cyc();
            RESET = 1;
         end
         cyc();
      end

      cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 8-bit single-datapath CPU: latches the opcode of each fetched instruction and steps FETCH/DECODE/EXEC/MEM/WB, driving the datapath control lines (regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop) plus PC/IR write enables.
- Handshakes with instruction memory (instr_valid) and data memory (mem_ready).
- Supports halt requests, a memory-timeout fault and a retired-instruction counter.
- Sits between the instruction/data memories and the datapath; the datapath's PC output feeds instruction memory.

Parameters:
- MEM_TIMEOUT, 15: max cycles waiting in MEM for mem_ready before FAULT; 0 disables the timeout.
- TO_W, 4: width of the timeout counter; must hold MEM_TIMEOUT.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- instruction  in  8  instruction word; [7:6] is the opcode: 00 add, 01 lw, 10 sw, 11 jmp.
- instr_valid  in  1  instruction memory has valid data for the current PC.
- mem_ready  in  1  data memory completed the access this cycle.
- halt_req  in  1  stop at the next instruction boundary; level-sensitive.
- ir_write  out  1  latch instruction into the datapath IR.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+1, 1 = jump target.
- regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop  out  1 each  datapath controls.
- state  out  3  current state encoding.
- retired  out  8  count of completed instructions.
- halted  out  1  controller is in HALT.
- fault  out  1  controller is in FAULT.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6. Codes 7+ go to FETCH.
- Reset (RESET=0, async): state=FETCH, opcode register=00, retired=0, timeout counter=0, all outputs 0.
- FETCH:
  - halt_req=1 has priority: go to HALT with no ir_write/pc_write, even if instr_valid=1.
  - Else if instr_valid=1: ir_write=1, pc_write=1, pc_src=0 (Mealy on instr_valid), latch opcode=instruction[7:6], go to DECODE.
  - Else stay in FETCH, all outputs 0.
- DECODE: 1 cycle, all controls 0, go to EXEC.
- EXEC (all outputs below are Moore, from state and latched opcode):
  - add: alusrc=0, aluop=1, then WB.
  - lw/sw: alusrc=1, aluop=0, then MEM.
  - jmp: pc_write=1, pc_src=1, branch=1, then FETCH; retired increments.
- MEM:
  - lw holds memread=1; sw holds memwrite=1; alusrc=1 held.
  - Stay until mem_ready=1. Then lw goes to WB; sw goes to FETCH and retired increments.
  - Timeout counter clears on MEM entry and increments each cycle mem_ready=0. If it reaches MEM_TIMEOUT (nonzero), go to FAULT; memread/memwrite drop on entry.
  - mem_ready=1 on the same cycle the timeout is reached: ready wins.
- WB:
  - add: regwrite=1, regdst=1, memtoreg=0.
  - lw: regwrite=1, regdst=0, memtoreg=1.
  - Then FETCH; retired increments.
- HALT: halted=1, all controls 0. When halt_req=0, go to FETCH next cycle.
- FAULT: fault=1, all controls 0; sticky until RESET.
- retired wraps 255 -> 0.
- Cycle counts with zero wait states: add=4, lw=5, sw=4, jmp=3.
- Reset asserted mid-MEM: memwrite/memread deassert immediately (async).

Optional Feature:
- SINGLE_STEP_EN defined:
  - Adds input port step (1 bit).
  - A step_pending flag is set when step=1 and cleared at FETCH acceptance.
  - FETCH accepts an instruction only when step_pending=1 (or step=1 that cycle); otherwise it waits in FETCH even if instr_valid=1.
  - halt_req priority is unchanged. step_pending resets to 0.
- SINGLE_STEP_EN undefined: no step port; free-running as above.

Test Plan:
- Reset, instr_valid=1 with add (00_01_10_11), mem_ready=1 -> states 0,1,2,4,0; regwrite=1 and regdst=1 in WB only; retired=1 after 4 cycles.
- lw (01xxxxxx) with mem_ready low 3 cycles -> memread=1 for 4 MEM cycles; WB memtoreg=1, regwrite=1; retired=1 after 8 cycles.
- sw with mem_ready held 0, MEM_TIMEOUT=15 -> FAULT after 15 MEM cycles; fault=1, memwrite=0; stays in FAULT until RESET=0.
- jmp (11xxxxxx) -> EXEC has pc_write=1, pc_src=1, branch=1; back to FETCH; 3-cycle instruction.
- halt_req=1 and instr_valid=1 together in FETCH -> HALT, no ir_write; drop halt_req -> FETCH next cycle, then accepts.
- Run 256 add instructions -> retired wraps to 0. Pulse RESET low mid-MEM of an sw -> memwrite=0 at once; state=FETCH after release.
